// File: rtl/packet_switch_fifo_rd_pkg.sv
// Shared types for the packet FIFO read-side controller.
// FIFO word layout is {sop, eop, data}; sop/eop offsets are relative to the payload width.
package packet_switch_fifo_rd_pkg;

  localparam int PKT_DWD = 64;
  localparam int SOP_OFS = 1;
  localparam int EOP_OFS = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PKT   = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [PKT_DWD-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/packet_switch_fifo_rd_ctrl_if.sv
// FIFO read port plus downstream valid/ready stream.
// The master side is the read controller; the slave side is the FIFO and the downstream stage.
interface packet_switch_fifo_rd_ctrl_if #(parameter int DWD = 64);

  logic [DWD+1:0] fifo_dout;
  logic           fifo_rdempty;
  logic           fifo_rdreq;
  logic [DWD-1:0] out_data;
  logic           out_sop;
  logic           out_eop;
  logic           out_valid;
  logic           out_ready;

  modport master (
    input  fifo_dout, fifo_rdempty, out_ready,
    output fifo_rdreq, out_data, out_sop, out_eop, out_valid
  );

  modport slave (
    output fifo_dout, fifo_rdempty, out_ready,
    input  fifo_rdreq, out_data, out_sop, out_eop, out_valid
  );

endinterface

// File: rtl/packet_switch_skid2.sv
// Two-entry registered buffer; head entry drives the output, occupancy is exported.
// Caller must not push when occ_o == 2 unless it also pops that cycle.
module packet_switch_skid2 #(
  parameter int W = 66
) (
  input  logic         clk1,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         vld_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   occ_q, occ_d;
  logic         vld_q, vld_d;
  logic         pop_ok;

  always_comb begin
    e0_d   = e0_q;
    e1_d   = e1_q;
    occ_d  = occ_q;
    pop_ok = pop_i && (occ_q != 2'd0);
    unique case ({push_i, pop_ok})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = push_dat_i;
        else               e1_d = push_dat_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the new word goes behind whatever remains.
        if (occ_q == 2'd1) begin
          e0_d = push_dat_i;
        end else begin
          e0_d = e1_q;
          e1_d = push_dat_i;
        end
      end
      default: ;
    endcase
    vld_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
      vld_q <= 1'b0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
      vld_q <= vld_d;
    end
  end

  assign head_o = e0_q;
  assign vld_o  = vld_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/packet_switch_fifo_rd_ctrl.sv
// Drains a show-ahead packet FIFO into a valid/ready stream, checking SOP/EOP framing,
// supporting a one-packet flush and counting delivered packets and dropped words.
module packet_switch_fifo_rd_ctrl
  import packet_switch_fifo_rd_pkg::*;
#(
  parameter int DWD   = PKT_DWD,
  parameter int CNT_W = 32
) (
  input  logic                         clk1,
  input  logic                         rst,
  packet_switch_fifo_rd_ctrl_if.master bus,
  input  logic                         flush_req,
  output logic                         flush_busy,
  output logic                         frm_err,
  output logic [CNT_W-1:0]             pkt_cnt,
  output logic [CNT_W-1:0]             drop_cnt
);

  rd_state_e        state_q;
  logic             flush_pend_q;
  logic             frm_err_q;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic [DWD+1:0]   head;
  logic             head_vld;
  logic [1:0]       occ;
  logic             w_sop, w_eop;
  logic             rdreq, push, discard, accept;

  assign w_sop = bus.fifo_dout[DWD+SOP_OFS];
  assign w_eop = bus.fifo_dout[DWD+EOP_OFS];

  // Pop depends only on registered state and FIFO status, never on out_ready.
  assign rdreq   = !bus.fifo_rdempty && ((state_q == FLUSH) || (occ != 2'd2));
  assign push    = rdreq && ((state_q == PKT) || ((state_q == IDLE) && w_sop));
  assign discard = rdreq && !push;
  assign accept  = head_vld && bus.out_ready;

  packet_switch_skid2 #(.W(DWD + 2)) u_skid (
    .clk1       (clk1),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (bus.fifo_dout),
    .pop_i      (bus.out_ready),
    .head_o     (head),
    .vld_o      (head_vld),
    .occ_o      (occ)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      frm_err_q    <= 1'b0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      if (accept && head[DWD+EOP_OFS]) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      if (discard)                     drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      if (flush_req)                   flush_pend_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (rdreq) begin
            if (!w_sop)      frm_err_q <= 1'b1;
            else if (!w_eop) state_q   <= PKT;
          end else if (flush_pend_q) begin
            state_q <= FLUSH;
          end
        end
        PKT: begin
          if (rdreq) begin
            // A stray SOP truncates the current packet and starts a new one.
            if (w_sop) frm_err_q <= 1'b1;
            if (w_eop) state_q   <= IDLE;
          end
        end
        FLUSH: begin
          if (rdreq && w_eop) begin
            flush_pend_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fifo_rdreq = rdreq;
  assign bus.out_data   = head[DWD-1:0];
  assign bus.out_sop    = head[DWD+SOP_OFS];
  assign bus.out_eop    = head[DWD+EOP_OFS];
  assign bus.out_valid  = head_vld;

  assign flush_busy = flush_pend_q || (state_q == FLUSH);
  assign frm_err    = frm_err_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_packet_switch_fifo_rd_ctrl.sv
// Bench for the FIFO read controller: queue-based FIFO and expected-output model,
// directed scenarios followed by randomized traffic.
module tb_packet_switch_fifo_rd_ctrl;
  import packet_switch_fifo_rd_pkg::*;

  localparam int DWD   = 64;
  localparam int CNT_W = 32;

  logic             clk1 = 1'b0;
  logic             rst;
  logic             flush_req;
  logic             flush_busy;
  logic             frm_err;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] drop_cnt;

  packet_switch_fifo_rd_ctrl_if #(.DWD(DWD)) bus ();

  packet_switch_fifo_rd_ctrl #(.DWD(DWD), .CNT_W(CNT_W)) dut (
    .clk1       (clk1),
    .rst        (rst),
    .bus        (bus),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .frm_err    (frm_err),
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk1 = ~clk1;

  int tests_run    = 0;
  int tests_failed = 0;
  int rdreq_seen   = 0;

  fifo_word_t  fifo_q[$];
  fifo_word_t  exp_q[$];
  bit          m_pkt, m_flush, m_pend, m_err;
  int unsigned m_pkts, m_drops;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input int len, input bit with_eop);
    fifo_word_t w;
    for (int i = 0; i < len; i++) begin
      w.sop  = (i == 0);
      w.eop  = with_eop && (i == len - 1);
      w.data = {$urandom, $urandom};
      fifo_q.push_back(w);
    end
  endtask

  task automatic push_stray();
    fifo_word_t w;
    w.sop  = 1'b0;
    w.eop  = 1'b0;
    w.data = {$urandom, $urandom};
    fifo_q.push_back(w);
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input bit rst_v, input bit rdy_v, input bit flush_v, input bit gap_v);
    bit         empty_v, pop, nxt_pend;
    fifo_word_t w;
    @(negedge clk1);
    rst           = rst_v;
    bus.out_ready = rdy_v;
    flush_req     = flush_v;
    empty_v       = rst_v || gap_v || (fifo_q.size() == 0);
    bus.fifo_rdempty = empty_v;
    if (!empty_v) bus.fifo_dout = fifo_q[0];
    #1;
    pop = !empty_v && (m_flush || exp_q.size() < 2);
    chk("rdreq", bus.fifo_rdreq, pop);
    chk("out_valid", bus.out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("out_data", bus.out_data, exp_q[0].data);
      chk("out_sop", bus.out_sop, exp_q[0].sop);
      chk("out_eop", bus.out_eop, exp_q[0].eop);
    end
    chk("flush_busy", flush_busy, m_pend || m_flush);
    chk("frm_err", frm_err, m_err);
    chk("pkt_cnt", pkt_cnt, m_pkts);
    chk("drop_cnt", drop_cnt, m_drops);
    if (bus.fifo_rdreq === 1'b1) rdreq_seen++;

    if (rst_v) begin
      exp_q.delete();
      {m_pkt, m_flush, m_pend, m_err} = '0;
      m_pkts  = 0;
      m_drops = 0;
    end else begin
      if (exp_q.size() != 0 && rdy_v) begin
        if (exp_q[0].eop) m_pkts++;
        void'(exp_q.pop_front());
      end
      nxt_pend = m_pend || flush_v;
      if (pop) begin
        w = fifo_q.pop_front();
        if (m_flush) begin
          m_drops++;
          if (w.eop) begin
            m_flush  = 1'b0;
            nxt_pend = 1'b0;
          end
        end else if (!m_pkt && !w.sop) begin
          m_err = 1'b1;
          m_drops++;
        end else begin
          if (m_pkt && w.sop) m_err = 1'b1;
          exp_q.push_back(w);
          m_pkt = !w.eop;
        end
      end else if (!m_pkt && !m_flush && m_pend) begin
        m_flush = 1'b1;
      end
      m_pend = nxt_pend;
    end
  endtask

  initial begin
    rst              = 1'b1;
    flush_req        = 1'b0;
    bus.out_ready    = 1'b0;
    bus.fifo_rdempty = 1'b1;
    bus.fifo_dout    = '0;
    {m_pkt, m_flush, m_pend, m_err} = '0;
    m_pkts  = 0;
    m_drops = 0;
    repeat (2) @(posedge clk1);

    // Back-to-back 4-word packet with downstream always ready
    push_pkt(4, 1'b1);
    rdreq_seen = 0;
    repeat (7) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_rdreq_cycles", rdreq_seen, 4);
    chk("t1_pkt_cnt", pkt_cnt, 1);

    // Same packet with out_ready toggling
    push_pkt(4, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, (i % 2) == 0, 1'b0, 1'b0);
    chk("t2_pkt_cnt", pkt_cnt, 2);

    // Non-SOP word between packets is dropped; the following packet passes
    push_stray();
    push_pkt(1, 1'b1);
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_frm_err", frm_err, 1);
    chk("t3_drop_cnt", drop_cnt, 1);
    chk("t3_pkt_cnt", pkt_cnt, 3);

    // Flush requested mid-packet A: A completes, B dropped, C delivered
    push_pkt(3, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_busy_wait", flush_busy, 1);
    push_pkt(2, 1'b1);
    push_pkt(2, 1'b1);
    repeat (8) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_drop_cnt", drop_cnt, 3);
    chk("t4_pkt_cnt", pkt_cnt, 5);
    chk("t4_busy_done", flush_busy, 0);

    // Reset mid-packet with both buffer entries full
    push_pkt(4, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_valid", bus.out_valid, 0);
    chk("t5_pkt_cnt", pkt_cnt, 0);
    chk("t5_drop_cnt", drop_cnt, 0);
    chk("t5_frm_err", frm_err, 0);
    repeat (6) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_resync_drops", drop_cnt, 2);
    chk("t5_resync_err", frm_err, 1);

    // SOP inside a packet truncates it
    fifo_q.delete();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    push_pkt(2, 1'b0);
    push_pkt(3, 1'b1);
    repeat (10) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_frm_err", frm_err, 1);
    chk("t6_pkt_cnt", pkt_cnt, 1);
    chk("t6_drop_cnt", drop_cnt, 0);

    // Randomized traffic with stray words, truncations, stalls and flushes
    for (int n = 0; n < 3000; n++) begin
      if (fifo_q.size() < 6) begin
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) push_stray();
        else        push_pkt($urandom_range(1, 5), r != 1);
      end
      cycle(1'b0, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
            $urandom_range(0, 4) == 0);
    end
    repeat (30) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("drain_valid", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
